// File: rtl/hex_digit_counter.sv
// hex_digit_counter: rate-divided multi-digit counter feeding 7-segment decoders.
// Optional HEX_DIGIT_COUNTER_BCD_EN makes each digit count decimal 0..9.
module hex_digit_counter #(
    parameter int DIV_MAX = 49999999,
    parameter int DIGITS  = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  load,
    input  logic [DIGITS*4-1:0]   load_value,
    output logic [DIGITS*4-1:0]   digits,
    output logic                  tick,
    output logic                  carry
);

    localparam int DW = (DIV_MAX < 2) ? 1 : $clog2(DIV_MAX + 1);
    localparam logic [DW-1:0] RELOAD = DW'(DIV_MAX);

`ifdef HEX_DIGIT_COUNTER_BCD_EN
    localparam logic [3:0] MAXD = 4'd9;
`else
    localparam logic [3:0] MAXD = 4'hF;
`endif

    logic [DW-1:0]         div_q;
    logic [DIGITS*4-1:0]   digits_q;
    logic                  tick_q;
    logic                  carry_q;

    logic [DIGITS*4-1:0]   nxt;
    logic [3:0]            d;
    logic                  c;

    // Ripple the +1/-1 through the digits; c left high means all wrapped.
    always_comb begin
        nxt = digits_q;
        d   = '0;
        c   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            d = digits_q[4*i +: 4];
            if (c) begin
                if (up) begin
`ifdef HEX_DIGIT_COUNTER_BCD_EN
                    if (d >= MAXD) begin
`else
                    if (d == MAXD) begin
`endif
                        nxt[4*i +: 4] = 4'd0;
                    end else begin
                        nxt[4*i +: 4] = d + 4'd1;
                        c = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        nxt[4*i +: 4] = MAXD;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
                    end else if (d > MAXD) begin
                        nxt[4*i +: 4] = MAXD;
                        c = 1'b0;
`endif
                    end else begin
                        nxt[4*i +: 4] = d - 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
    end

    // Divider, digit register and one-cycle step pulses.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            div_q    <= RELOAD;
            digits_q <= '0;
            tick_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else if (load) begin
            div_q    <= RELOAD;
            digits_q <= load_value;
            tick_q   <= 1'b0;
            carry_q  <= 1'b0;
        end else if (enable) begin
            if (div_q == '0) begin
                div_q    <= RELOAD;
                digits_q <= nxt;
                tick_q   <= 1'b1;
                carry_q  <= c;
            end else begin
                div_q    <= div_q - DW'(1);
                tick_q   <= 1'b0;
                carry_q  <= 1'b0;
            end
        end else begin
            tick_q  <= 1'b0;
            carry_q <= 1'b0;
        end
    end

    assign digits = digits_q;
    assign tick   = tick_q;
    assign carry  = carry_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// tb_hex_digit_counter: scoreboard bench with a count-level reference model.
// Build with +define+HEX_DIGIT_COUNTER_BCD_EN to exercise the decimal variant.
module tb_hex_digit_counter;

    localparam int DIV_MAX = 3;
    localparam int DIGITS  = 2;
    localparam int W       = DIGITS * 4;

    typedef struct {
        int           cyc;
        logic [W-1:0] d;
        logic         t;
        logic         c;
    } exp_t;

    logic         clock = 1'b0;
    logic         resetn = 1'b0;
    logic         enable = 1'b0;
    logic         up = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] load_value = '0;
    logic [W-1:0] digits;
    logic         tick;
    logic         carry;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [W-1:0] m_val = '0;
    int           m_cnt = 0;

    hex_digit_counter #(.DIV_MAX(DIV_MAX), .DIGITS(DIGITS)) dut (
        .clock(clock),
        .resetn(resetn),
        .enable(enable),
        .up(up),
        .load(load),
        .load_value(load_value),
        .digits(digits),
        .tick(tick),
        .carry(carry)
    );

    always #5 clock = ~clock;

    // Returns {wrap, next value} for one count step.
    function automatic logic [W:0] step_of(input logic [W-1:0] v,
                                           input logic dir);
        logic [W-1:0] nv;
        logic         wrap;
`ifdef HEX_DIGIT_COUNTER_BCD_EN
        int k;
        nv = v;
        k = 0;
        while (k < DIGITS && ((dir && v[4*k +: 4] >= 4'd9) ||
                              (!dir && v[4*k +: 4] == 4'd0)))
            k++;
        wrap = (k == DIGITS);
        for (int j = 0; j < k; j++)
            nv[4*j +: 4] = dir ? 4'd0 : 4'd9;
        if (!wrap) begin
            if (dir)
                nv[4*k +: 4] = v[4*k +: 4] + 4'd1;
            else if (v[4*k +: 4] > 4'd9)
                nv[4*k +: 4] = 4'd9;
            else
                nv[4*k +: 4] = v[4*k +: 4] - 4'd1;
        end
`else
        if (dir) begin
            wrap = (v == {W{1'b1}});
            nv = v + 1'b1;
        end else begin
            wrap = (v == '0);
            nv = v - 1'b1;
        end
`endif
        return {wrap, nv};
    endfunction

    // Reference model: counts enabled cycles since the last restart and
    // queues what the DUT must present after this edge.
    always @(posedge clock) begin
        logic [W:0] r;
        exp_t e;
        cyc = cyc + 1;
        e.cyc = cyc;
        e.t = 1'b0;
        e.c = 1'b0;
        if (!resetn) begin
            m_val = '0;
            m_cnt = 0;
        end else if (load) begin
            m_val = load_value;
            m_cnt = 0;
        end else if (enable) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == DIV_MAX + 1) begin
                m_cnt = 0;
                r = step_of(m_val, up);
                m_val = r[W-1:0];
                e.t = 1'b1;
                e.c = r[W];
            end
        end
        e.d = m_val;
        q.push_back(e);
    end

    // Monitor: compares whatever the DUT shows against the queued response.
    always @(negedge clock) begin
        exp_t e;
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            checks++;
            if (digits !== e.d || tick !== e.t || carry !== e.c) begin
                errors++;
                $display("FAIL cyc%0d out: got d=%h t=%b c=%b want d=%h t=%b c=%b",
                         cyc, digits, tick, carry, e.d, e.t, e.c);
            end
        end else if (cyc > 0) begin
            checks++;
            errors++;
            $display("FAIL cyc%0d sb: no expected entry (got d=%h t=%b c=%b)",
                     cyc, digits, tick, carry);
        end
    end

    task automatic drive(input logic rn, input logic en, input logic u,
                         input logic ld, input logic [W-1:0] lv,
                         input int n);
        resetn = rn;
        enable = en;
        up = u;
        load = ld;
        load_value = lv;
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b1, 1'b0, '0, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 8);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFE, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 9);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 4);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 4);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h20, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 2);
        drive(1'b1, 1'b0, 1'b1, 1'b0, '0, 10);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 2);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 6);
`ifdef HEX_DIGIT_COUNTER_BCD_EN
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h09, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 4);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h99, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 4);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 4);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 8'h0C, 1);
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 4);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'hC0, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, 4);
`endif
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 59) != 0),
                  ($urandom_range(0, 7) != 0),
                  1'(($urandom >> 3) & 1),
                  ($urandom_range(0, 19) == 0),
                  W'($urandom),
                  1);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b0, '0, 3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
